emap_row_writer: RTL and testbench

EMAP_ROW_WRITER -- requirements
Module: emap_row_writer

---
 rtl/emap_row_writer_pkg.sv | 28 ++
 rtl/emap_row_writer.sv | 166 ++++++++++++++++
 tb/tb_emap_row_writer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/emap_row_writer_pkg.sv
// ---------------------------------------------------------------------------
// emap_row_writer_pkg
//   Shared element-map definitions. The row writer and the gather side both
//   use these, so the memory geometry stays in one place.
//   - emap_state_e        : job state enumeration (IDLE/COLLECT/FLUSH/DONE)
//   - EMAP_ELEMENT_WIDTH  : default width of one vector element
//   - EMAP_NO_OF_UNITS    : default number of elements per memory row
//   - EMAP_ADDRESS_WIDTH  : default memory row address width
// ---------------------------------------------------------------------------
package emap_row_writer_pkg;

    localparam int EMAP_ELEMENT_WIDTH = 32;
    localparam int EMAP_NO_OF_UNITS   = 8;
    localparam int EMAP_ADDRESS_WIDTH = 20;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FLUSH   = 2'd2,
        S_DONE    = 2'd3
    } emap_state_e;

    // Width of a slot index; at least one bit so a one-slot row still works.
    function automatic int emap_slot_w(input int units);
        return (units > 1) ? $clog2(units) : 1;
    endfunction

endpackage

// File: rtl/emap_row_writer.sv
// ---------------------------------------------------------------------------
// emap_row_writer
//   Packs a stream of result elements into element-map memory rows. Each
//   accepted element lands in the next slot of the row being collected
//   (slot 0 in the MSBs). When the row fills, or the job's last element
//   arrives, the row is registered and written one cycle later at
//   base_address + row index. Collection continues without a stall while
//   the previous row is being written.
//
//   Ports
//     clk, reset      : clock, synchronous active-high reset
//     start           : one-cycle pulse starting a job (ignored while busy)
//     base_address    : first row address, sampled on start
//     no_of_elements  : job length in elements, sampled on start
//     data_in/valid   : element stream; accepted when data_valid && in_ready
//     in_ready        : high every cycle of the COLLECT state
//     write_enable    : one-cycle row write strobe
//     write_address   : row address for the write
//     input_data      : packed row for the write
//     busy            : high from start acceptance through the done cycle
//     done            : one-cycle pulse ending the job
//
//   Build option
//     EMAP_ROW_WRITER_ZERO_FILL_EN : when defined, the collect buffer is
//     cleared at every row start so unfilled slots of a final partial row
//     are written as zero. When undefined, the buffer is only cleared by
//     reset and unfilled slots carry the previous row's contents.
// ---------------------------------------------------------------------------
module emap_row_writer
    import emap_row_writer_pkg::*;
#(
    parameter int element_width = EMAP_ELEMENT_WIDTH,
    parameter int no_of_units   = EMAP_NO_OF_UNITS,
    parameter int address_width = EMAP_ADDRESS_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [address_width-1:0]             base_address,
    input  logic [31:0]                          no_of_elements,
    input  logic [element_width-1:0]             data_in,
    input  logic                                 data_valid,
    output logic                                 in_ready,
    output logic                                 write_enable,
    output logic [address_width-1:0]             write_address,
    output logic [no_of_units*element_width-1:0] input_data,
    output logic                                 busy,
    output logic                                 done
);

    localparam int ROW_W  = no_of_units * element_width;
    localparam int SLOT_W = emap_slot_w(no_of_units);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(no_of_units - 1);

    emap_state_e                r_state;
    emap_state_e                w_state_next;
    logic [31:0]                r_n;          // job length
    logic [31:0]                r_count;      // elements accepted so far
    logic [SLOT_W-1:0]          r_slot;       // next slot to fill
    logic [address_width-1:0]   r_row_addr;   // address of the row being collected
    logic [ROW_W-1:0]           r_row;        // collect buffer
    logic                       r_we;
    logic [address_width-1:0]   r_waddr;
    logic [ROW_W-1:0]           r_wdata;

    logic                       w_accept;
    logic                       w_last;
    logic                       w_row_full;
    logic [ROW_W-1:0]           w_row_next;

    assign w_accept   = data_valid && (r_state == S_COLLECT);
    assign w_last     = w_accept && (r_count == (r_n - 32'd1));
    assign w_row_full = w_accept && (r_slot == LAST_SLOT);

    // Collect buffer with the incoming element merged into its slot; this is
    // what gets registered for the write when the row closes.
    always_comb begin
        w_row_next = r_row;
        if (w_accept) begin
            for (int s = 0; s < no_of_units; s++) begin
                if (SLOT_W'(s) == r_slot)
                    w_row_next[(no_of_units-s)*element_width-1 -: element_width] = data_in;
            end
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_state_next = (no_of_elements == 32'd0) ? S_DONE : S_COLLECT;
            end
            S_COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_last)
                    w_state_next = S_FLUSH;
            end
            S_FLUSH: begin
                busy         = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_count    <= '0;
            r_slot     <= '0;
            r_row_addr <= '0;
            r_row      <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_state_next;
            r_we    <= 1'b0;

            if (r_state == S_IDLE && start) begin
                r_n        <= no_of_elements;
                r_count    <= '0;
                r_slot     <= '0;
                r_row_addr <= base_address;
            end

            if (w_accept) begin
                r_count <= r_count + 32'd1;
                if (w_row_full || w_last) begin
                    // Close the row: hand it to the write register and keep
                    // collecting into the buffer on the very next cycle.
                    r_we       <= 1'b1;
                    r_waddr    <= r_row_addr;
                    r_wdata    <= w_row_next;
                    r_row_addr <= r_row_addr + address_width'(1);
                    r_slot     <= '0;
`ifdef EMAP_ROW_WRITER_ZERO_FILL_EN
                    r_row      <= '0;
`else
                    r_row      <= w_row_next;
`endif
                end else begin
                    r_slot <= r_slot + SLOT_W'(1);
                    r_row  <= w_row_next;
                end
            end
        end
    end

    assign write_enable  = r_we;
    assign write_address = r_waddr;
    assign input_data    = r_wdata;

endmodule

// File: tb/tb_emap_row_writer.sv
// ---------------------------------------------------------------------------
// tb_emap_row_writer
//   Random and directed packing jobs. The driver computes each expected row
//   write (address, packed contents, cycle) and the done cycle from the
//   element list it sends and pushes them into queues; a monitor on the
//   falling edge pops and compares whenever write_enable or done is seen.
// ---------------------------------------------------------------------------
module tb_emap_row_writer;

    localparam int EW = 32;
    localparam int NU = 8;
    localparam int AW = 20;
    localparam int W  = NU * EW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_address;
    logic [31:0]   no_of_elements;
    logic [EW-1:0] data_in;
    logic          data_valid;
    logic          in_ready;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [W-1:0]  input_data;
    logic          busy;
    logic          done;

    emap_row_writer #(
        .element_width (EW),
        .no_of_units   (NU),
        .address_width (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_address   (base_address),
        .no_of_elements (no_of_elements),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .in_ready       (in_ready),
        .write_enable   (write_enable),
        .write_address  (write_address),
        .input_data     (input_data),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        int            c;
    } wexp_t;

    wexp_t         wq[$];
    int            dq[$];
    logic [EW-1:0] mrow [NU];   // model of the collect buffer contents

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b want %0b at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_w(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] pack_row();
        logic [W-1:0] p;
        p = '0;
        for (int r = 0; r < NU; r++) p[(NU-r)*EW-1 -: EW] = mrow[r];
        return p;
    endfunction

    task automatic clear_model();
        for (int r = 0; r < NU; r++) mrow[r] = '0;
    endtask

    // Monitor / scoreboard
    wexp_t m_e;
    int    m_dc;
    always @(negedge clk) begin
        if (wq.size() > 0 && wq[0].c < cyc) begin
            n_tests++; n_fail++;
            $display("FAIL write_missing: got none want addr %0h at cycle %0d", wq[0].a, wq[0].c);
            void'(wq.pop_front());
        end
        if (dq.size() > 0 && dq[0] < cyc) begin
            n_tests++; n_fail++;
            $display("FAIL done_missing: got none want done at cycle %0d", dq[0]);
            void'(dq.pop_front());
        end
        if (write_enable) begin
            if (wq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL write_unexpected: got addr %0h want no write at cycle %0d", write_address, cyc);
            end else begin
                m_e = wq.pop_front();
                chk_i("write_cycle", cyc, m_e.c);
                chk_i("write_addr", int'(write_address), int'(m_e.a));
                chk_w("write_data", input_data, m_e.d);
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL done_unexpected: got done want none at cycle %0d", cyc);
            end else begin
                m_dc = dq.pop_front();
                chk_i("done_cycle", cyc, m_dc);
            end
        end
    end

    // gap: 0 back-to-back, 1 every other cycle, 2 random.
    // seq: data k+1 instead of random. rst_at: assert reset after that many
    // elements have been accepted (-1 for none). Returns with DUT in IDLE.
    task automatic run_job(input logic [AW-1:0] base, input int n, input int gap,
                           input bit seq, input int rst_at);
        int            k;
        bit            v;
        bit            ph;
        logic [EW-1:0] e;
        k  = 0;
        ph = 1'b1;
        chk_b("idle_busy", busy, 1'b0);
        chk_b("idle_in_ready", in_ready, 1'b0);
        if (n == 0) dq.push_back(cyc + 1);
        start          = 1'b1;
        base_address   = base;
        no_of_elements = n;
        @(negedge clk);
        start          = 1'b0;
        base_address   = AW'($urandom);
        no_of_elements = $urandom_range(1, 50);
        if (n == 0) begin
            chk_b("zero_busy", busy, 1'b1);
            @(negedge clk);
            return;
        end
        while (k < n) begin
            chk_b("in_ready", in_ready, 1'b1);
            chk_b("busy", busy, 1'b1);
            if (rst_at == k) begin
                start      = 1'b0;
                data_valid = 1'b0;
                reset      = 1'b1;
                @(negedge clk);
                chk_b("rst_in_ready", in_ready, 1'b0);
                chk_b("rst_we", write_enable, 1'b0);
                chk_i("rst_waddr", int'(write_address), 0);
                chk_w("rst_wdata", input_data, '0);
                chk_b("rst_busy", busy, 1'b0);
                chk_b("rst_done", done, 1'b0);
                reset = 1'b0;
                clear_model();
                return;
            end
            if (gap == 0)      v = 1'b1;
            else if (gap == 1) begin v = ph; ph = ~ph; end
            else               v = ($urandom_range(0, 2) != 0);
            // stray start pulses while busy must be ignored
            start          = ($urandom_range(0, 7) == 0);
            no_of_elements = $urandom_range(0, 50);
            if (v) begin
                e          = seq ? EW'(k + 1) : EW'($urandom);
                data_valid = 1'b1;
                data_in    = e;
                mrow[k % NU] = e;
                if ((k % NU) == NU - 1 || k == n - 1) begin
                    wq.push_back('{a: base + AW'(k / NU), d: pack_row(), c: cyc + 1});
`ifdef EMAP_ROW_WRITER_ZERO_FILL_EN
                    clear_model();
`endif
                end
                if (k == n - 1) dq.push_back(cyc + 2);
                k++;
            end else begin
                data_valid = 1'b0;
                data_in    = EW'($urandom);
            end
            @(negedge clk);
        end
        // FLUSH: stray data must not be taken
        start      = 1'b0;
        data_valid = 1'b1;
        data_in    = EW'($urandom);
        chk_b("flush_in_ready", in_ready, 1'b0);
        chk_b("flush_busy", busy, 1'b1);
        @(negedge clk);
        data_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish by 200000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        base_address   = '0;
        no_of_elements = '0;
        data_in        = '0;
        data_valid     = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        chk_b("reset_in_ready", in_ready, 1'b0);
        chk_b("reset_we", write_enable, 1'b0);
        chk_i("reset_waddr", int'(write_address), 0);
        chk_w("reset_wdata", input_data, '0);
        chk_b("reset_busy", busy, 1'b0);
        chk_b("reset_done", done, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        run_job(AW'('h00010), 8, 0, 1'b1, -1);
        run_job(AW'($urandom), 20, 0, 1'b0, -1);
        run_job(AW'($urandom), 0, 0, 1'b0, -1);
        run_job(AW'($urandom), 9, 1, 1'b1, -1);
        run_job(AW'('hFFFFF), 16, 0, 1'b0, -1);
        run_job(AW'('h00010), 8, 0, 1'b1, 5);
        run_job(AW'('h00010), 8, 0, 1'b1, -1);
        for (int j = 0; j < 25; j++)
            run_job(AW'($urandom), $urandom_range(0, 40), $urandom_range(0, 2), 1'b0, -1);

        repeat (4) @(negedge clk);
        chk_i("write_queue_drained", wq.size(), 0);
        chk_i("done_queue_drained", dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
